block_buffer: RTL and testbench

BLOCK_BUFFER -- requirements
Module: block_buffer

---
 rtl/block_buffer_if.sv | 30 +++
 rtl/block_buffer.sv | 159 +++++++++++++++
 tb/tb_block_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_buffer_if.sv
// rtl/block_buffer_if.sv - word-in / block-out handshake bundle for block_buffer
interface block_buffer_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
);
  localparam int BLK_W = WORD_W * WORDS;
  localparam int IB_W  = $clog2(WORD_W / 8) + 1;
  localparam int OB_W  = $clog2(BLK_W / 8 + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic [IB_W-1:0]   in_bytes;
  logic              out_valid;
  logic              out_ready;
  logic [BLK_W-1:0]  out_data;
  logic              out_last;
  logic [OB_W-1:0]   out_bytes;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_bytes
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_last, out_bytes
  );
endinterface

// File: rtl/block_buffer.sv
// rtl/block_buffer.sv - packs message words into blocks; optional Ascon 0x01 padding under ASCON_PAD_EN
module block_buffer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  block_buffer_if.slave bus
);
  localparam int WB    = WORD_W / 8;
  localparam int BLK_W = WORD_W * WORDS;
  localparam int OB_W  = $clog2(BLK_W / 8 + 1);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef ASCON_PAD_EN
  localparam int BLK_B = BLK_W / 8;
`endif

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1
`ifdef ASCON_PAD_EN
    , PAD = 2'd2
`endif
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [BLK_W-1:0]  storage;
  logic              last_q;
  logic [OB_W-1:0]   bytes_q;
`ifdef ASCON_PAD_EN
  // set when a full-size last block still owes the trailing pad-only block
  logic              pad_pending;
`endif

  logic              in_fire, out_fire, complete;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] masked;
  logic [BLK_W-1:0]  blk_wr;
  logic [OB_W-1:0]   bytes_wr;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign bus.out_last  = last_q;
  assign bus.out_bytes = bytes_q;

  // Block image after writing the incoming word; a word taken in FULL starts a fresh block at index 0
  always_comb begin
    wr_idx   = (state == FILL) ? idx : '0;
    complete = (int'(wr_idx) == WORDS - 1) || bus.in_last;
    masked   = '0;
    for (int b = 0; b < WB; b++) begin
      masked[8*b +: 8] = (!bus.in_last || b < int'(bus.in_bytes)) ? bus.in_data[8*b +: 8] : 8'h00;
    end
    blk_wr = (state == FILL) ? storage : '0;
    blk_wr[int'(wr_idx)*WORD_W +: WORD_W] = masked;
    bytes_wr = OB_W'(int'(wr_idx) * WB + (bus.in_last ? int'(bus.in_bytes) : WB));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // Next-state logic; clear overrides any handshake in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      FILL: if (in_fire && complete) state_nx = FULL;
      FULL: begin
        if (out_fire) begin
          if (in_fire)           state_nx = complete ? FULL : FILL;
`ifdef ASCON_PAD_EN
          else if (pad_pending)  state_nx = PAD;
`endif
          else                   state_nx = FILL;
        end
      end
`ifdef ASCON_PAD_EN
      PAD:  if (out_fire) state_nx = FILL;
`endif
      default: state_nx = FILL;
    endcase
    if (clear) state_nx = FILL;
  end

  // Handshake outputs and presented block, including the 0x01 pad byte when enabled
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = (state != FILL);
    bus.out_data  = storage;
    case (state)
      FILL:    bus.in_ready = 1'b1;
`ifdef ASCON_PAD_EN
      FULL:    bus.in_ready = bus.out_ready && !pad_pending;
`else
      FULL:    bus.in_ready = bus.out_ready;
`endif
      default: bus.in_ready = 1'b0;
    endcase
`ifdef ASCON_PAD_EN
    if (last_q && int'(bytes_q) < BLK_B) begin
      bus.out_data = storage | (BLK_W'(1) << (8 * int'(bytes_q)));
    end
`endif
  end

  // Block storage, word index and block descriptors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      storage <= '0;
      idx     <= '0;
      last_q  <= 1'b0;
      bytes_q <= '0;
`ifdef ASCON_PAD_EN
      pad_pending <= 1'b0;
`endif
    end else if (clear) begin
      storage <= '0;
      idx     <= '0;
      last_q  <= 1'b0;
      bytes_q <= '0;
`ifdef ASCON_PAD_EN
      pad_pending <= 1'b0;
`endif
    end else if (in_fire) begin
      storage <= blk_wr;
      if (complete) begin
        idx     <= '0;
        bytes_q <= bytes_wr;
        last_q  <= bus.in_last;
`ifdef ASCON_PAD_EN
        pad_pending <= bus.in_last && (int'(bytes_wr) == BLK_B);
        if (bus.in_last && int'(bytes_wr) == BLK_B) last_q <= 1'b0;
`endif
      end else begin
        idx     <= wr_idx + IDX_W'(1);
        bytes_q <= '0;
        last_q  <= 1'b0;
`ifdef ASCON_PAD_EN
        pad_pending <= 1'b0;
`endif
      end
    end else if (out_fire) begin
      // storage is zeroed so the pad-only block is just the 0x01 byte at position 0
      storage <= '0;
      idx     <= '0;
      bytes_q <= '0;
`ifdef ASCON_PAD_EN
      last_q      <= pad_pending;
      pad_pending <= 1'b0;
`else
      last_q  <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_block_buffer.sv
// tb/tb_block_buffer.sv - scoreboard bench for block_buffer with a byte-stream reference model
module tb_block_buffer;
  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int WB     = WORD_W / 8;
  localparam int BLK_W  = WORD_W * WORDS;
  localparam int BLK_B  = BLK_W / 8;

  typedef struct {
    logic [BLK_W-1:0] data;
    int               bytes;
    bit               last;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  block_buffer_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();
  block_buffer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus));

  blk_t              exp_q[$];
  blk_t              mon_e;
  int                checks = 0;
  int                errors = 0;
  int                stalls = 0;
  bit                rand_ready = 1'b0;
  logic [WORD_W-1:0] wbuf [0:15];

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // random consumer back-pressure
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: every transferred block is compared against the oldest expected block
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %h expected none", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("blk_data", bus.out_data, mon_e.data);
        chk("blk_bytes", BLK_W'(bus.out_bytes), BLK_W'(mon_e.bytes));
        chk("blk_last", BLK_W'(bus.out_last), BLK_W'(mon_e.last));
      end
    end
  end

  task automatic send_word(input logic [WORD_W-1:0] d, input logic last, input logic [2:0] nb);
    int t;
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nb;
    t = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected acceptance within 200 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Model: the message is a byte stream; each block takes WORDS words' worth of bytes, packed from byte 0
  task automatic send_msg(input int n, input int lb);
    int   nchunks, cnt, nb;
    blk_t b, p;
    nchunks = (n + WORDS - 1) / WORDS;
    for (int c = 0; c < nchunks; c++) begin
      b.data = '0;
      cnt = 0;
      for (int i = c * WORDS; i < n && i < (c + 1) * WORDS; i++) begin
        nb = (i == n - 1) ? lb : WB;
        for (int k = 0; k < nb; k++) begin
          b.data[8*cnt +: 8] = wbuf[i][8*k +: 8];
          cnt++;
        end
      end
      b.bytes = cnt;
      b.last  = (c == nchunks - 1);
`ifdef ASCON_PAD_EN
      if (b.last && cnt < BLK_B) b.data[8*cnt +: 8] = 8'h01;
      if (b.last && cnt == BLK_B) begin
        b.last = 1'b0;
        exp_q.push_back(b);
        p.data  = BLK_W'(1);
        p.bytes = 0;
        p.last  = 1'b1;
        exp_q.push_back(p);
      end else begin
        exp_q.push_back(b);
      end
`else
      exp_q.push_back(b);
`endif
    end
    for (int i = 0; i < n; i++) begin
      send_word(wbuf[i], i == n - 1, (i == n - 1) ? 3'(lb) : 3'($urandom_range(0, 4)));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", BLK_W'(exp_q.size()), BLK_W'(0));
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", BLK_W'(bus.in_ready), BLK_W'(1));
    chk("rst_out_valid", BLK_W'(bus.out_valid), BLK_W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_bytes", BLK_W'(bus.out_bytes), BLK_W'(0));
    chk("rst_out_last", BLK_W'(bus.out_last), BLK_W'(0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // full 16-byte last block
    wbuf[0] = 32'h03020100; wbuf[1] = 32'h07060504;
    wbuf[2] = 32'h0B0A0908; wbuf[3] = 32'h0F0E0D0C;
    send_msg(4, 4);
    idle();
    drain();

    // short last word
    wbuf[0] = 32'h11111111; wbuf[1] = 32'hDDCCBBAA;
    send_msg(2, 2);
    idle();
    drain();

    // empty message
    wbuf[0] = 32'hFFFFFFFF;
    send_msg(1, 0);
    idle();
    drain();

    // consumer stall holds the block and blocks input
    bus.out_ready = 1'b0;
    rand_words(4);
    send_msg(4, 3);
    idle();
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", BLK_W'(bus.in_ready), BLK_W'(0));
      chk("hold_out_data", bus.out_data, exp_q[0].data);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    stalls = 0;
    rand_words(8);
    send_msg(8, 4);
    idle();
    chk("no_bubble_stalls", BLK_W'(stalls), BLK_W'(0));
    drain();

    // clear after two words, asserted together with a presented word
    send_word($urandom, 1'b0, 3'd4);
    send_word($urandom, 1'b0, 3'd4);
    bus.in_data = $urandom;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    idle();
    @(negedge clk);
    chk("clear_out_valid", BLK_W'(bus.out_valid), BLK_W'(0));
    chk("clear_storage", bus.out_data, '0);
    chk("clear_in_ready", BLK_W'(bus.in_ready), BLK_W'(1));
    @(posedge clk);
    #1;
    rand_words(4);
    send_msg(4, 4);
    idle();
    drain();

    // asynchronous reset after two words
    send_word($urandom, 1'b0, 3'd4);
    send_word($urandom, 1'b0, 3'd4);
    idle();
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", BLK_W'(bus.out_valid), BLK_W'(0));
    chk("arst_storage", bus.out_data, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rand_words(4);
    send_msg(4, 4);
    idle();
    drain();

    // randomized messages under random back-pressure
    rand_ready = 1'b1;
    repeat (40) begin
      rand_words(9);
      send_msg($urandom_range(1, 9), $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
